// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width and the divide sequencer state encoding.
package cpu_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      WRITE  = 2'd2
   } state_e;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO register pair: divider results take priority, mthi/mtlo only when idle.
module hilo_regs
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              div_we,
   input  logic              busy,
   input  logic [DATA_W-1:0] div_quo,
   input  logic [DATA_W-1:0] div_rem,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              hi_we,
   input  logic              lo_we,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);

   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   // Next HI/LO: divider write wins, otherwise move-to writes while not busy.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (div_we) begin
         hi_d = div_rem;
         lo_d = div_quo;
      end else if (!busy) begin
         if (hi_we) hi_d = wr_data;
         if (lo_we) lo_d = wr_data;
      end
   end

   // HI/LO storage, cleared asynchronously.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: rtl/div_hilo_sequencer.sv
// Multicycle divide controller: latches operands for the combinational
// divider, waits SETTLE_CYCLES clocks, then commits quotient/remainder to LO/HI.
module div_hilo_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W        = cpu_pkg::DATA_W,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 3
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              start,
   input  logic [DATA_W-1:0] op_dividend,
   input  logic [DATA_W-1:0] op_divisor,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero,
   output logic [DATA_W-1:0] div_dividend,
   output logic [DATA_W-1:0] div_divisor,
   input  logic [DATA_W-1:0] div_quo,
   input  logic [DATA_W-1:0] div_rem,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              hi_we,
   input  logic              lo_we,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] dividend_q, dividend_d;
   logic [DATA_W-1:0] divisor_q, divisor_d;
   logic              dbz_q, dbz_d;
   logic              done_q, done_d;
   logic              div_we;

   // Next-state, operand latch, settle counter and done pulse.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      dbz_d      = dbz_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               dividend_d = op_dividend;
               divisor_d  = op_divisor;
               dbz_d      = (op_divisor == '0);
               if (op_divisor == '0) begin
                  // Nothing to wait for: skip straight to the (suppressed) write.
                  state_d = WRITE;
               end else begin
                  cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                  state_d = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = WRITE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WRITE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and operand registers, cleared asynchronously.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         dbz_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         dbz_q      <= dbz_d;
         done_q     <= done_d;
      end
   end

   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign div_by_zero  = dbz_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;
   assign div_we       = (state_q == WRITE) && !dbz_q;

   hilo_regs #(
      .DATA_W(DATA_W)
   ) u_hilo_regs (
      .clock   (clock),
      .clear_n (clear_n),
      .div_we  (div_we),
      .busy    (busy),
      .div_quo (div_quo),
      .div_rem (div_rem),
      .wr_data (wr_data),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .hi_out  (hi_out),
      .lo_out  (lo_out)
   );

endmodule

// File: tb/tb_div_hilo_sequencer.sv
// Bench for div_hilo_sequencer with a behavioural divider attached.
module tb_div_hilo_sequencer;

   localparam int unsigned W  = 32;
   localparam int unsigned SC = 4;

   logic         clock = 1'b0;
   logic         clear_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] op_dividend = '0;
   logic [W-1:0] op_divisor = '0;
   logic [W-1:0] wr_data = '0;
   logic         hi_we = 1'b0;
   logic         lo_we = 1'b0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] div_dividend, div_divisor, div_quo, div_rem, hi_out, lo_out;

   int n_cmp = 0;
   int n_mis = 0;
   bit chk_en = 1'b0;

   // reference model state (transaction level)
   bit           m_busy, m_done, m_dbz;
   int           m_remain;
   logic [W-1:0] m_a, m_b, m_hi, m_lo, r_hi, r_lo;

   always #5 clock = ~clock;

   // combinational signed divider beside the sequencer
   always_comb begin
      if (div_divisor == '0) begin
         div_quo = '0;
         div_rem = '0;
      end else begin
         div_quo = $signed(div_dividend) / $signed(div_divisor);
         div_rem = $signed(div_dividend) % $signed(div_divisor);
      end
   end

   div_hilo_sequencer #(
      .DATA_W(W),
      .SETTLE_CYCLES(SC),
      .CNT_W(3)
   ) dut (
      .clock(clock), .clear_n(clear_n), .start(start),
      .op_dividend(op_dividend), .op_divisor(op_divisor),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quo(div_quo), .div_rem(div_rem),
      .wr_data(wr_data), .hi_we(hi_we), .lo_we(lo_we),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   function automatic void cmp(string name, logic [W-1:0] act, logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // every-cycle comparison against the model
   always @(negedge clock) begin
      if (chk_en) begin
         cmp("busy", W'(busy), W'(m_busy));
         cmp("done", W'(done), W'(m_done));
         cmp("div_by_zero", W'(div_by_zero), W'(m_dbz));
         cmp("div_dividend", div_dividend, m_a);
         cmp("div_divisor", div_divisor, m_b);
         cmp("hi_out", hi_out, m_hi);
         cmp("lo_out", lo_out, m_lo);
      end
   end

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_dbz = 0; m_remain = 0;
      m_a = '0; m_b = '0; m_hi = '0; m_lo = '0; r_hi = '0; r_lo = '0;
   endtask

   // one clock: model predicts from current inputs, then the edge happens
   task automatic tick();
      bit           n_busy = m_busy, n_done = 1'b0, n_dbz = m_dbz;
      int           n_remain = m_remain;
      logic [W-1:0] n_a = m_a, n_b = m_b, n_hi = m_hi, n_lo = m_lo;
      logic [W-1:0] n_rhi = r_hi, n_rlo = r_lo;
      if (m_busy) begin
         n_remain = m_remain - 1;
         if (n_remain == 0) begin
            n_busy = 1'b0;
            n_done = 1'b1;
            if (!m_dbz) begin
               n_hi = r_hi;
               n_lo = r_lo;
            end
         end
      end else begin
         if (hi_we) n_hi = wr_data;
         if (lo_we) n_lo = wr_data;
         if (start) begin
            n_a    = op_dividend;
            n_b    = op_divisor;
            n_dbz  = (op_divisor == '0);
            n_busy = 1'b1;
            if (op_divisor == '0) begin
               n_remain = 1;
            end else begin
               n_remain = SC + 1;
               n_rlo = $signed(op_dividend) / $signed(op_divisor);
               n_rhi = $signed(op_dividend) % $signed(op_divisor);
            end
         end
      end
      @(posedge clock);
      m_busy = n_busy; m_done = n_done; m_dbz = n_dbz; m_remain = n_remain;
      m_a = n_a; m_b = n_b; m_hi = n_hi; m_lo = n_lo; r_hi = n_rhi; r_lo = n_rlo;
      @(negedge clock);
      #1;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      if (!done) begin
         n_cmp++;
         n_mis++;
         $display("FAIL done_timeout: got no done expected done within 20 cycles at %0t", $time);
      end
   endtask

   // start at E0 and return the number of edges after E0 until done is seen
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      int l;
      start = 1'b1; op_dividend = a; op_divisor = b;
      tick();
      start = 1'b0;
      wait_done(l);
      lat = l;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish by 100000");
      $fatal(1);
   end

   initial begin
      int lat;
      int dcount;
      model_reset();
      #1 clear_n = 1'b0;
      #2;
      cmp("rst_busy", W'(busy), '0);
      cmp("rst_done", W'(done), '0);
      cmp("rst_dbz", W'(div_by_zero), '0);
      cmp("rst_hi", hi_out, '0);
      cmp("rst_lo", lo_out, '0);
      cmp("rst_dividend", div_dividend, '0);
      @(negedge clock); #1;
      clear_n = 1'b1;
      chk_en  = 1'b1;
      tick();

      // nominal 100/7
      run_div(32'd100, 32'd7, lat);
      cmp("lat_nominal", W'(lat), W'(5));
      cmp("lo_100_7", lo_out, 32'd14);
      cmp("hi_100_7", hi_out, 32'd2);
      tick();
      cmp("done_one_cycle", W'(done), '0);

      // signed operands
      run_div(32'hFFFF_FF9C, 32'd7, lat);
      cmp("lo_m100_7", lo_out, 32'hFFFF_FFF2);
      cmp("hi_m100_7", hi_out, 32'hFFFF_FFFE);
      tick();
      run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, lat);
      cmp("lo_m100_m7", lo_out, 32'd14);
      cmp("hi_m100_m7", hi_out, 32'hFFFF_FFFE);
      tick();

      // divide by zero keeps preloaded HI/LO
      hi_we = 1'b1; wr_data = 32'hA5A5_A5A5;
      tick();
      hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h5A5A_5A5A;
      tick();
      lo_we = 1'b0;
      run_div(32'd55, 32'd0, lat);
      cmp("lat_zero", W'(lat), W'(1));
      cmp("dbz_set", W'(div_by_zero), W'(1));
      cmp("hi_kept", hi_out, 32'hA5A5_A5A5);
      cmp("lo_kept", lo_out, 32'h5A5A_5A5A);
      tick();
      run_div(32'd9, 32'd3, lat);
      cmp("dbz_cleared", W'(div_by_zero), '0);
      cmp("lo_9_3", lo_out, 32'd3);
      cmp("hi_9_3", hi_out, 32'd0);
      tick();

      // start while busy is ignored; back-to-back start in done cycle
      start = 1'b1; op_dividend = 32'd100; op_divisor = 32'd7;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; op_dividend = 32'd8; op_divisor = 32'd2;
      tick();
      start = 1'b0;
      cmp("busy_start_dividend", div_dividend, 32'd100);
      wait_done(lat);
      cmp("busy_start_lo", lo_out, 32'd14);
      run_div(32'd8, 32'd2, lat);
      cmp("lat_b2b", W'(lat), W'(5));
      cmp("lo_8_2", lo_out, 32'd4);
      tick();

      // mt writes gated while busy, honoured in idle
      start = 1'b1; op_dividend = 32'd100; op_divisor = 32'd7;
      tick();
      start = 1'b0;
      hi_we = 1'b1; wr_data = 32'h1234;
      tick();
      hi_we = 1'b0;
      cmp("hi_gated", hi_out, 32'd0);
      wait_done(lat);
      cmp("hi_after_gated", hi_out, 32'd2);
      hi_we = 1'b1; wr_data = 32'h1234;
      tick();
      hi_we = 1'b0;
      cmp("hi_mt_idle", hi_out, 32'h1234);
      // coincident start and mtlo; then both mt strobes together
      start = 1'b1; op_dividend = 32'd9; op_divisor = 32'd3;
      lo_we = 1'b1; wr_data = 32'hDEAD;
      tick();
      start = 1'b0; lo_we = 1'b0;
      cmp("lo_mt_with_start", lo_out, 32'hDEAD);
      wait_done(lat);
      cmp("lo_overwritten", lo_out, 32'd3);
      hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hCAFE;
      tick();
      hi_we = 1'b0; lo_we = 1'b0;
      cmp("hi_both", hi_out, 32'hCAFE);
      cmp("lo_both", lo_out, 32'hCAFE);

      // reset during SETTLE
      start = 1'b1; op_dividend = 32'd100; op_divisor = 32'd7;
      tick();
      start = 1'b0;
      tick();
      clear_n = 1'b0;
      model_reset();
      #1;
      cmp("midrst_busy", W'(busy), '0);
      cmp("midrst_done", W'(done), '0);
      cmp("midrst_hi", hi_out, '0);
      cmp("midrst_lo", lo_out, '0);
      cmp("midrst_dividend", div_dividend, '0);
      cmp("midrst_divisor", div_divisor, '0);
      #1 clear_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) dcount++;
      end
      cmp("midrst_no_done", W'(dcount), '0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
